aska_hbridge_driver: RTL and testbench

ASKA_HBRIDGE_DRIVER -- requirements
Module: aska_hbridge_driver

---
 rtl/aska_hbridge_driver.sv | 167 ++++++++++++++++
 tb/tb_aska_hbridge_driver.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aska_hbridge_driver.sv
`default_nettype none
// ============================================================================
//  Module   : aska_hbridge_driver
//  Purpose  : Break-before-make H-bridge gate driver for an electrode array.
//             Accepts P/N switch patterns from a pulse generator, inserts a
//             programmable all-off dead interval whenever a new pattern is
//             accepted, refuses shoot-through patterns, clamps the DAC code to
//             a safety ceiling and latches faults until acknowledged.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             enable                - 0 returns the driver to IDLE
//             up_req / down_req     - requested P / N switch patterns (32 b)
//             dac_req               - requested DAC code (6 b)
//             dead_time             - break-before-make length in cycles (4 b)
//             max_amplitude         - DAC safety ceiling (6 b)
//             fault_in, fault_clear - external fault, fault acknowledge
//             up_drv / down_drv     - registered gate enables (32 b)
//             dac_out               - registered, clamped DAC code (6 b)
//             dac_clamped           - dac_req above ceiling (combinational)
//             fault                 - fault latched
//             phase_count           - saturating count of accepted phases
//  Revision : 1.0 - initial release
// ============================================================================
module aska_hbridge_driver #(
    parameter int DEAD_MIN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] up_req,
    input  logic [31:0] down_req,
    input  logic [5:0]  dac_req,
    input  logic [3:0]  dead_time,
    input  logic [5:0]  max_amplitude,
    input  logic        fault_in,
    input  logic        fault_clear,
    output logic [31:0] up_drv,
    output logic [31:0] down_drv,
    output logic [5:0]  dac_out,
    output logic        dac_clamped,
    output logic        fault,
    output logic [15:0] phase_count
);

    localparam int c_DCNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DEAD  = 2'd1,
        S_DRIVE = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_n;
    logic [63:0]           r_pat;
    logic [63:0]           w_pat_n;
    logic [c_DCNT_W-1:0]   r_dcnt;
    logic [c_DCNT_W-1:0]   w_dcnt_n;
    logic                  w_phase_inc;

    logic [63:0]           w_req;
    logic                  w_req_nz;
    logic                  w_conflict;
    logic                  w_fault_cond;
    logic [c_DCNT_W-1:0]   w_dead_len;
    logic [5:0]            w_dac_clamp;

    assign w_req        = {up_req, down_req};
    assign w_req_nz     = |w_req;
    assign w_conflict   = |(up_req & down_req);
    assign w_fault_cond = fault_in | w_conflict;

    // Dead interval never shorter than the build-time floor.
    assign w_dead_len = ({12'd0, dead_time} > c_DCNT_W'(DEAD_MIN)) ?
                        {12'd0, dead_time} : c_DCNT_W'(DEAD_MIN);

    assign dac_clamped = (dac_req > max_amplitude);
    assign w_dac_clamp = dac_clamped ? max_amplitude : dac_req;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n   = r_state;
        w_pat_n     = r_pat;
        w_dcnt_n    = r_dcnt;
        w_phase_inc = 1'b0;

        if (w_fault_cond) begin
            // Faults and shoot-through requests override everything else.
            w_state_n = S_FAULT;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (enable && w_req_nz) begin
                        w_pat_n     = w_req;
                        w_dcnt_n    = w_dead_len;
                        w_phase_inc = 1'b1;
                        w_state_n   = S_DEAD;
                    end
                end
                S_DEAD: begin
                    if (!enable) begin
                        w_state_n = S_IDLE;
                    end else if (r_dcnt <= c_DCNT_W'(1)) begin
                        w_state_n = S_DRIVE;
                    end else begin
                        w_dcnt_n = r_dcnt - c_DCNT_W'(1);
                    end
                end
                S_DRIVE: begin
                    if (!enable || !w_req_nz) begin
                        w_state_n = S_IDLE;
                    end else if (w_req != r_pat) begin
                        w_pat_n     = w_req;
                        w_dcnt_n    = w_dead_len;
                        w_phase_inc = 1'b1;
                        w_state_n   = S_DEAD;
                    end
                end
                S_FAULT: begin
                    // Only an explicit acknowledge leaves FAULT; enable=0 does not.
                    if (fault_clear) begin
                        w_state_n = S_IDLE;
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and registered outputs. Outputs are computed from the next
    // state so that they line up with the state register cycle for cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pat       <= '0;
            r_dcnt      <= '0;
            phase_count <= '0;
            up_drv      <= '0;
            down_drv    <= '0;
            dac_out     <= '0;
            fault       <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_pat   <= w_pat_n;
            r_dcnt  <= w_dcnt_n;
            if (w_phase_inc && (phase_count != 16'hFFFF)) begin
                phase_count <= phase_count + 16'd1;
            end
            if (w_state_n == S_DRIVE) begin
                up_drv   <= w_pat_n[63:32];
                down_drv <= w_pat_n[31:0];
                dac_out  <= w_dac_clamp;
            end else begin
                up_drv   <= '0;
                down_drv <= '0;
                dac_out  <= '0;
            end
            fault <= (w_state_n == S_FAULT);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aska_hbridge_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aska_hbridge_driver
//  Purpose  : Self-checking bench for aska_hbridge_driver. A phase-level
//             reference model tracks the expected outputs; directed scenarios
//             pin literal values and randomized traffic exercises the rest.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aska_hbridge_driver;

    localparam int C_DEAD_MIN = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] up_req;
    logic [31:0] down_req;
    logic [5:0]  dac_req;
    logic [3:0]  dead_time;
    logic [5:0]  max_amplitude;
    logic        fault_in;
    logic        fault_clear;
    logic [31:0] up_drv;
    logic [31:0] down_drv;
    logic [5:0]  dac_out;
    logic        dac_clamped;
    logic        fault;
    logic [15:0] phase_count;

    int errors = 0;
    int checks = 0;

    aska_hbridge_driver #(.DEAD_MIN(C_DEAD_MIN)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .up_req        (up_req),
        .down_req      (down_req),
        .dac_req       (dac_req),
        .dead_time     (dead_time),
        .max_amplitude (max_amplitude),
        .fault_in      (fault_in),
        .fault_clear   (fault_clear),
        .up_drv        (up_drv),
        .down_drv      (down_drv),
        .dac_out       (dac_out),
        .dac_clamped   (dac_clamped),
        .fault         (fault),
        .phase_count   (phase_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a phase is either absent, in its dead interval
    // (m_dead_left zero-output cycles still to come) or driving.
    // ------------------------------------------------------------------
    bit          m_valid = 1'b0;
    bit          m_fault;
    bit          m_active;
    int          m_dead_left;
    logic [63:0] m_pat;
    int          m_cnt;
    logic [5:0]  m_dac;

    function automatic int dead_len(input logic [3:0] dt);
        return (int'(dt) > C_DEAD_MIN) ? int'(dt) : C_DEAD_MIN;
    endfunction

    always @(posedge clk) begin
        logic [63:0] req;
        req = {up_req, down_req};
        if (reset) begin
            m_valid = 1'b1; m_fault = 1'b0; m_active = 1'b0;
            m_dead_left = 0; m_pat = '0; m_cnt = 0;
        end else if (fault_in || ((up_req & down_req) != 0)) begin
            m_fault = 1'b1; m_active = 1'b0;
        end else if (m_fault) begin
            if (fault_clear) m_fault = 1'b0;
        end else if (!enable) begin
            m_active = 1'b0;
        end else if (!m_active || m_dead_left == 0) begin
            // No phase yet, or driving: a new nonzero pattern starts a phase.
            if (req == 0) begin
                m_active = 1'b0;
            end else if (!m_active || req != m_pat) begin
                m_active = 1'b1; m_pat = req; m_dead_left = dead_len(dead_time);
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            end
        end else begin
            m_dead_left--;
        end
        if (m_active && m_dead_left == 0 && !m_fault)
            m_dac = (dac_req > max_amplitude) ? max_amplitude : dac_req;
        else
            m_dac = '0;
    end

    // Per-cycle comparison against the model plus safety invariants.
    logic [31:0] prev_up = '0;
    logic [31:0] prev_down = '0;
    always @(negedge clk) begin
        bit drive;
        if (m_valid) begin
            drive = m_active && m_dead_left == 0 && !m_fault;
            chk("up_drv", 64'(up_drv), drive ? 64'(m_pat[63:32]) : 64'd0);
            chk("down_drv", 64'(down_drv), drive ? 64'(m_pat[31:0]) : 64'd0);
            chk("dac_out", 64'(dac_out), 64'(m_dac));
            chk("fault", 64'(fault), 64'(m_fault));
            chk("phase_count", 64'(phase_count), 64'(m_cnt));
            chk("dac_clamped", 64'(dac_clamped), 64'(dac_req > max_amplitude));
            chk("no_shoot_through", 64'(up_drv & down_drv), 64'd0);
            chk("break_before_make", 64'((prev_up & down_drv) | (prev_down & up_drv)), 64'd0);
            prev_up   = up_drv;
            prev_down = down_drv;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] u, input logic [31:0] d);
        up_req = u; down_req = d;
    endtask

    logic [31:0] pool [8];

    initial begin
        pool[0] = 32'h0;        pool[1] = 32'h1;        pool[2] = 32'h2;
        pool[3] = 32'h4;        pool[4] = 32'h80000000; pool[5] = 32'h0000_00F0;
        pool[6] = 32'h0001_0003; pool[7] = 32'h5;

        reset = 1'b1; enable = 1'b1; set_req(0, 0); dac_req = 6'd20;
        dead_time = 4'd3; max_amplitude = 6'd63; fault_in = 1'b0; fault_clear = 1'b0;
        tick(3);
        chk("reset_phase_count", 64'(phase_count), 64'd0);
        chk("reset_up_drv", 64'(up_drv), 64'd0);
        chk("reset_fault", 64'(fault), 64'd0);

        // First phase with dead_time=3: drive appears at cycle 4.
        reset = 1'b0; set_req(32'h1, 32'h2);
        for (int c = 1; c <= 3; c++) begin
            tick(1);
            chk("first_dead_up", 64'(up_drv), 64'd0);
            chk("first_dead_down", 64'(down_drv), 64'd0);
        end
        tick(1);
        chk("first_up", 64'(up_drv), 64'h1);
        chk("first_down", 64'(down_drv), 64'h2);
        chk("first_phase", 64'(phase_count), 64'd1);
        chk("first_dac", 64'(dac_out), 64'd20);

        // DAC clamp.
        dac_req = 6'd40; max_amplitude = 6'd30; #1;
        chk("clamp_flag", 64'(dac_clamped), 64'd1);
        tick(1);
        chk("clamp_dac", 64'(dac_out), 64'd30);

        // Swap polarity; dead_time change mid-dead must not stretch it.
        set_req(32'h2, 32'h1);
        tick(1);
        chk("swap_dead_dac", 64'(dac_out), 64'd0);
        dead_time = 4'd9;
        for (int c = 2; c <= 3; c++) begin
            tick(1);
            chk("swap_dead_up", 64'(up_drv), 64'd0);
            chk("swap_dead_down", 64'(down_drv), 64'd0);
        end
        tick(1);
        chk("swap_up", 64'(up_drv), 64'h2);
        chk("swap_down", 64'(down_drv), 64'h1);
        chk("swap_phase", 64'(phase_count), 64'd2);
        dead_time = 4'd3;

        // enable=0 drops to IDLE; re-enable restarts a phase.
        enable = 1'b0; tick(1);
        chk("disable_up", 64'(up_drv), 64'd0);
        enable = 1'b1; tick(1);
        chk("reenable_phase", 64'(phase_count), 64'd3);
        tick(3);

        // Shoot-through request latches a fault; clear needs conflict gone.
        set_req(32'h4, 32'h4); tick(1);
        chk("conflict_fault", 64'(fault), 64'd1);
        chk("conflict_up", 64'(up_drv), 64'd0);
        chk("conflict_dac", 64'(dac_out), 64'd0);
        fault_clear = 1'b1; tick(1);
        chk("clear_blocked", 64'(fault), 64'd1);
        set_req(0, 0); tick(1);
        chk("clear_fault", 64'(fault), 64'd0);
        fault_clear = 1'b0;

        // dead_time=0 -> single dead cycle.
        dead_time = 4'd0; set_req(32'h1, 32'h0);
        tick(1);
        chk("dt0_dead", 64'(up_drv), 64'd0);
        tick(1);
        chk("dt0_drive", 64'(up_drv), 64'h1);

        // fault_in mid-dead.
        dead_time = 4'd3; set_req(32'h8, 32'h0); tick(1);
        fault_in = 1'b1; tick(1);
        chk("midfault_fault", 64'(fault), 64'd1);
        chk("midfault_up", 64'(up_drv), 64'd0);
        fault_in = 1'b0; set_req(0, 0); fault_clear = 1'b1; tick(1);
        fault_clear = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] u, d;
            u = pool[$urandom_range(0, 7)];
            d = pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) != 0) d = d & ~u;
            set_req(u, d);
            dac_req       = 6'($urandom);
            max_amplitude = 6'($urandom);
            dead_time     = 4'($urandom_range(0, 4));
            fault_in      = ($urandom_range(0, 49) == 0);
            fault_clear   = ($urandom_range(0, 2) == 0);
            enable        = ($urandom_range(0, 19) != 0);
            reset         = ($urandom_range(0, 99) == 0);
            tick($urandom_range(1, 6));
        end

        // Saturation of phase_count, then reset mid-drive.
        reset = 1'b1; enable = 1'b1; fault_in = 1'b0; fault_clear = 1'b0;
        dead_time = 4'd0; dac_req = 6'd10; max_amplitude = 6'd63; set_req(0, 0);
        tick(2);
        reset = 1'b0;
        for (int i = 0; i < 65540; i++) begin
            if (i % 2 == 0) set_req(32'h1, 32'h2); else set_req(32'h2, 32'h1);
            tick(2);
        end
        chk("sat_phase", 64'(phase_count), 64'hFFFF);
        tick(1);
        chk("sat_drive_up", 64'(up_drv), 64'h2);
        chk("sat_drive_dac", 64'(dac_out), 64'd10);
        reset = 1'b1; tick(1);
        chk("rst_up", 64'(up_drv), 64'd0);
        chk("rst_down", 64'(down_drv), 64'd0);
        chk("rst_dac", 64'(dac_out), 64'd0);
        chk("rst_phase", 64'(phase_count), 64'd0);
        reset = 1'b0; set_req(0, 0); tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
